mem_arbiter: RTL and testbench

Shares the single byte-wide RAM/IO bus between three requesters: instruction-fetch misses, loads and committed stores. It grants one request at a time and sequences the 1/2/4 byte transfers onto the bus as single-byte cycles. Sits between the instruction cache, the load/store unit and the top-level memory pins. Honours pipeline flush for speculative reads and never drops a committed store.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_grant_ctrl.sv | 75 +++++++
 rtl/mem_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the byte-wide memory bus arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        OWN_IF = 2'd0,
        OWN_LD = 2'd1,
        OWN_ST = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] LEN_1B = 2'd0;
    localparam logic [1:0] LEN_2B = 2'd1;
    localparam logic [1:0] LEN_4B = 2'd2;

    // Side-effecting IO lives at and above this address; multi-byte reads there are unsafe.
    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    function automatic logic [2:0] bytes_of(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_1B:  n = 3'd1;
            LEN_2B:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic is_io(input logic [31:0] addr);
        return (addr >= IO_BASE);
    endfunction

endpackage

// File: rtl/mem_grant_ctrl.sv
// Request priority and ifetch starvation guard; produces the grant taken in IDLE.
module mem_grant_ctrl
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       flush_in,
    input  logic       idle,
    input  logic       abort,
    input  logic       if_req,
    input  logic       ld_req,
    input  logic       st_req,
    output logic       grant_valid,
    output logic [1:0] grant_owner
);

    logic [3:0] starve_r;
    logic       at_limit_s;

    assign at_limit_s = (starve_r == 4'(STARVE_LIMIT));

    // Grant selection: forced ifetch, then store, then load, then ifetch; flush blocks reads.
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWN_IF;
        if (idle && rdy_in) begin
            if (if_req && !flush_in && at_limit_s) begin
                grant_valid = 1'b1;
                grant_owner = OWN_IF;
            end else if (st_req) begin
                grant_valid = 1'b1;
                grant_owner = OWN_ST;
            end else if (flush_in) begin
                grant_valid = 1'b0;
            end else if (ld_req) begin
                grant_valid = 1'b1;
                grant_owner = OWN_LD;
            end else if (if_req) begin
                grant_valid = 1'b1;
                grant_owner = OWN_IF;
            end else begin
                grant_valid = 1'b0;
            end
        end else begin
            grant_valid = 1'b0;
        end
    end

    // Count data grants that passed over a waiting ifetch; saturates at the limit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            starve_r <= 4'd0;
        end else if (!rdy_in) begin
            starve_r <= starve_r;
        end else if (abort) begin
            starve_r <= 4'd0;
        end else if (idle) begin
            if (!if_req) begin
                starve_r <= 4'd0;
            end else if (grant_valid && (grant_owner == OWN_IF)) begin
                starve_r <= 4'd0;
            end else if (grant_valid && !at_limit_s) begin
                starve_r <= starve_r + 4'd1;
            end else begin
                starve_r <= starve_r;
            end
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates ifetch/load/store onto the byte-wide RAM bus and serialises each
// 1/2/4-byte transfer into single-byte bus cycles.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [1:0]            ld_len,
    output logic                  ld_done,
    output logic [31:0]           ld_data,
    input  logic                  st_req,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [1:0]            st_len,
    input  logic [31:0]           st_data,
    output logic                  st_done
);

    state_e                  state_r, state_nxt_s;
    owner_e                  owner_r, gown_s;
    logic [ADDR_WIDTH-1:0]   addr_r, mem_a_r, gnt_addr_s;
    logic [2:0]              nbytes_r, idx_r, nidx_s;
    logic [1:0]              cidx_s, gnt_len_s;
    logic [31:0]             wdata_r, if_data_r, ld_data_r;
    logic [7:0]              mem_dout_r;
    logic                    mem_wr_r, if_done_r, ld_done_r, st_done_r;
    logic                    grant_valid_s, idle_s, kill_s, abort_s;
    logic [1:0]              grant_owner_s;

    assign idle_s  = (state_r == IDLE);
    assign kill_s  = flush_in && rdy_in;
    assign abort_s = kill_s && (owner_r != OWN_ST) && ((state_r == READ) || (state_r == DONE));
    assign gown_s  = owner_e'(grant_owner_s);
    assign nidx_s  = idx_r + 3'd1;
    assign cidx_s  = idx_r[1:0] - 2'd1;

    mem_grant_ctrl #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .idle        (idle_s),
        .abort       (abort_s),
        .if_req      (if_req),
        .ld_req      (ld_req),
        .st_req      (st_req),
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );

    // Address and length of the winning requester.
    always_comb begin
        gnt_addr_s = if_addr;
        gnt_len_s  = LEN_4B;
        case (gown_s)
            OWN_ST: begin
                gnt_addr_s = st_addr;
                gnt_len_s  = st_len;
            end
            OWN_LD: begin
                gnt_addr_s = ld_addr;
                gnt_len_s  = ld_len;
            end
            default: begin
                gnt_addr_s = if_addr;
                gnt_len_s  = LEN_4B;
            end
        endcase
    end

    // Next-state logic; a read reaches DONE one cycle after its last address to capture the byte.
    always_comb begin
        state_nxt_s = state_r;
        if (!rdy_in) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        state_nxt_s = (gown_s == OWN_ST) ? WRITE : READ;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                READ: begin
                    if (abort_s) begin
                        state_nxt_s = IDLE;
                    end else if (idx_r == nbytes_r) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = READ;
                    end
                end
                WRITE: begin
                    if (nidx_s == nbytes_r) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = WRITE;
                    end
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Byte sequencer, bus drivers, capture buffers and done pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            owner_r    <= OWN_IF;
            addr_r     <= '0;
            nbytes_r   <= 3'd0;
            idx_r      <= 3'd0;
            wdata_r    <= 32'd0;
            mem_a_r    <= '0;
            mem_dout_r <= 8'd0;
            mem_wr_r   <= 1'b0;
            if_done_r  <= 1'b0;
            ld_done_r  <= 1'b0;
            st_done_r  <= 1'b0;
            if_data_r  <= 32'd0;
            ld_data_r  <= 32'd0;
        end else if (!rdy_in) begin
            // mem_din is meaningless across a pause, so a read starts over from byte 0.
            if (state_r == READ) begin
                idx_r   <= 3'd0;
                mem_a_r <= addr_r;
            end else begin
                idx_r   <= idx_r;
            end
        end else begin
            if_done_r <= 1'b0;
            ld_done_r <= 1'b0;
            st_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r  <= gown_s;
                        addr_r   <= gnt_addr_s;
                        nbytes_r <= bytes_of(gnt_len_s);
                        idx_r    <= 3'd0;
                        wdata_r  <= st_data;
                        mem_a_r  <= gnt_addr_s;
                        if (gown_s == OWN_ST) begin
                            mem_wr_r   <= 1'b1;
                            mem_dout_r <= st_data[7:0];
                        end else if (gown_s == OWN_LD) begin
                            ld_data_r <= 32'd0;
                        end else begin
                            if_data_r <= 32'd0;
                        end
                    end else begin
                        mem_a_r <= '0;
                    end
                end
                READ: begin
                    if (abort_s) begin
                        idx_r     <= 3'd0;
                        mem_a_r   <= '0;
                        if_data_r <= 32'd0;
                        ld_data_r <= 32'd0;
                    end else begin
                        if (idx_r != 3'd0) begin
                            if (owner_r == OWN_LD) begin
                                ld_data_r[{cidx_s, 3'b000} +: 8] <= mem_din;
                            end else begin
                                if_data_r[{cidx_s, 3'b000} +: 8] <= mem_din;
                            end
                        end
                        if (idx_r == nbytes_r) begin
                            idx_r     <= 3'd0;
                            mem_a_r   <= '0;
                            ld_done_r <= (owner_r == OWN_LD);
                            if_done_r <= (owner_r == OWN_IF);
                        end else begin
                            idx_r   <= nidx_s;
                            mem_a_r <= (nidx_s == nbytes_r) ? '0 : addr_r + ADDR_WIDTH'(nidx_s);
                        end
                    end
                end
                WRITE: begin
                    if (nidx_s == nbytes_r) begin
                        idx_r      <= 3'd0;
                        mem_a_r    <= '0;
                        mem_dout_r <= 8'd0;
                        mem_wr_r   <= 1'b0;
                        st_done_r  <= 1'b1;
                    end else begin
                        idx_r      <= nidx_s;
                        mem_a_r    <= addr_r + ADDR_WIDTH'(nidx_s);
                        mem_dout_r <= wdata_r[{nidx_s[1:0], 3'b000} +: 8];
                    end
                end
                DONE: begin
                    if (abort_s) begin
                        if_data_r <= 32'd0;
                        ld_data_r <= 32'd0;
                    end else begin
                        idx_r <= 3'd0;
                    end
                end
                default: begin
                    idx_r <= 3'd0;
                end
            endcase
        end
    end

    // A flushed read must never show its done pulse, even in the DONE cycle itself.
    assign mem_a    = mem_a_r;
    assign mem_dout = mem_dout_r;
    assign mem_wr   = mem_wr_r && rdy_in;
    assign if_done  = if_done_r && !kill_s;
    assign ld_done  = ld_done_r && !kill_s;
    assign st_done  = st_done_r;
    assign if_data  = if_data_r;
    assign ld_data  = ld_data_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transfers plus
// sequences for starvation, flush, pause and asynchronous reset.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, ld_req, st_req;
    logic [31:0] if_addr, ld_addr, st_addr, st_data;
    logic [1:0]  ld_len, st_len;
    logic        if_done, ld_done, st_done;
    logic [31:0] if_data, ld_data;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count;
    logic [7:0] ram [0:4095];

    mem_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_done(st_done)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: read data one cycle after the address; preloaded while reset is low.
    always @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22; ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
            ram[12'h300] <= 8'h5A; ram[12'h301] <= 8'h6B;
            ram[12'hFFE] <= 8'hA1; ram[12'hFFF] <= 8'hB2; ram[12'h000] <= 8'hC3; ram[12'h001] <= 8'hD4;
            ram[12'h202] <= 8'hEE; ram[12'h203] <= 8'h77;
            wr_count <= 0;
            mem_din  <= 8'h00;
        end else begin
            mem_din <= ram[mem_a[11:0]];
            if (mem_wr) begin
                ram[mem_a[11:0]] <= mem_dout;
                wr_count <= wr_count + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [11:0] b;
        b = a[11:0];
        return {ram[b + 12'd3], ram[b + 12'd2], ram[b + 12'd1], ram[b]};
    endfunction

    task automatic drop_reqs();
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    endtask

    // kind: 0 load, 1 store, 2 ifetch. done_k is the cycle offset from the grant (0 = no done pulse).
    task automatic do_txn(input string name, input int kind, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] wdata,
                          input int flush_k, input int pause_k, input int pause_n,
                          output int done_k, output logic [31:0] data, output int nwr);
        int w0;
        w0 = wr_count;
        done_k = 0;
        data = 32'd0;
        case (kind)
            0: begin ld_addr = addr; ld_len = len; ld_req = 1'b1; end
            1: begin st_addr = addr; st_len = len; st_data = wdata; st_req = 1'b1; end
            default: begin if_addr = addr; if_req = 1'b1; end
        endcase
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_in);
            if (k == 1 && pause_k != 1) chk({name, " first mem_a"}, mem_a, addr);
            if (if_done || ld_done || st_done) begin
                done_k = k;
                data = (kind == 2) ? if_data : ld_data;
                break;
            end
            flush_in = (k == flush_k);
            if (k == flush_k) drop_reqs();
            rdy_in = !(k >= pause_k && k < pause_k + pause_n);
            if (!rdy_in) begin
                #1;
                chk({name, " mem_wr while paused"}, {31'd0, mem_wr}, 32'd0);
            end
        end
        drop_reqs();
        flush_in = 1'b0;
        rdy_in = 1'b1;
        @(negedge clk_in);
        chk({name, " done single cycle"}, {29'd0, if_done, ld_done, st_done}, 32'd0);
        nwr = wr_count - w0;
    endtask

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          exp_k;
        int          exp_nwr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int dk, nw;
        logic [31:0] d;
        int seq[6];
        int cnt;

        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        if_addr = 32'd0; ld_addr = 32'd0; st_addr = 32'd0; st_data = 32'd0;
        ld_len = 2'd0; st_len = 2'd0;
        repeat (3) @(negedge clk_in);
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset mem_wr/dout", {23'd0, mem_wr, mem_dout}, 32'd0);
        chk("reset dones", {29'd0, if_done, ld_done, st_done}, 32'd0);
        chk("reset if_data", if_data, 32'd0);
        chk("reset ld_data", ld_data, 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        vecs[0] = '{"ld 4B 0x100",   0, 32'h0000_0100, 2'd2, 32'h0,          32'h4433_2211, 6, 0};
        vecs[1] = '{"ld 2B 0x100",   0, 32'h0000_0100, 2'd1, 32'h0,          32'h0000_2211, 4, 0};
        vecs[2] = '{"ld 1B 0x300",   0, 32'h0000_0300, 2'd0, 32'h0,          32'h0000_005A, 3, 0};
        vecs[3] = '{"ld 4B wrap",    0, 32'hFFFF_FFFE, 2'd3, 32'h0,          32'hD4C3_B2A1, 6, 0};
        vecs[4] = '{"if 0x100",      2, 32'h0000_0100, 2'd0, 32'h0,          32'h4433_2211, 6, 0};
        vecs[5] = '{"st 2B 0x200",   1, 32'h0000_0200, 2'd1, 32'hAABB_CCDD,  32'h77EE_CCDD, 3, 2};
        vecs[6] = '{"st 1B 0x210",   1, 32'h0000_0210, 2'd0, 32'h1234_5678,  32'h0000_0078, 2, 1};
        vecs[7] = '{"st 4B 0x220",   1, 32'h0000_0220, 2'd3, 32'hCAFE_F00D,  32'hCAFE_F00D, 5, 4};
        vecs[8] = '{"ld back 0x220", 0, 32'h0000_0220, 2'd2, 32'h0,          32'hCAFE_F00D, 6, 0};

        foreach (vecs[i]) begin
            do_txn(vecs[i].name, vecs[i].kind, vecs[i].addr, vecs[i].len, vecs[i].wdata, 0, 0, 0, dk, d, nw);
            chk({vecs[i].name, " done cycle"}, dk, vecs[i].exp_k);
            chk({vecs[i].name, " bytes written"}, nw, vecs[i].exp_nwr);
            if (vecs[i].kind == 1) chk({vecs[i].name, " ram"}, ram_word(vecs[i].addr), vecs[i].exp);
            else                   chk({vecs[i].name, " data"}, d, vecs[i].exp);
        end

        // Starvation: loads back-to-back while ifetch waits.
        if_addr = 32'h100; ld_addr = 32'h300; ld_len = 2'd0;
        if_req = 1'b1; ld_req = 1'b1;
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 6; c++) begin
            @(negedge clk_in);
            if (ld_done)      begin seq[cnt] = 1; cnt++; end
            else if (if_done) begin seq[cnt] = 2; cnt++; end
        end
        drop_reqs();
        chk("starve done count", cnt, 6);
        for (int j = 0; j < 6; j++) chk($sformatf("starve order %0d", j), (j < cnt) ? seq[j] : 0, (j == 4) ? 2 : 1);
        repeat (2) @(negedge clk_in);

        do_txn("flush if", 2, 32'h100, 2'd2, 32'h0, 2, 0, 0, dk, d, nw);
        chk("flush if no done", dk, 0);
        chk("flush if no write", nw, 0);
        chk("flush if data cleared", if_data, 32'd0);

        do_txn("flush st", 1, 32'h230, 2'd2, 32'h0102_0304, 2, 0, 0, dk, d, nw);
        chk("flush st done cycle", dk, 5);
        chk("flush st bytes", nw, 4);
        chk("flush st ram", ram_word(32'h230), 32'h0102_0304);

        do_txn("pause ld", 0, 32'h100, 2'd2, 32'h0, 0, 2, 3, dk, d, nw);
        chk("pause ld done cycle", dk, 10);
        chk("pause ld data", d, 32'h4433_2211);

        do_txn("pause st", 1, 32'h240, 2'd2, 32'h5566_7788, 0, 2, 3, dk, d, nw);
        chk("pause st done cycle", dk, 8);
        chk("pause st bytes", nw, 4);
        chk("pause st ram", ram_word(32'h240), 32'h5566_7788);

        // Asynchronous reset in the middle of a store.
        st_addr = 32'h250; st_len = 2'd2; st_data = 32'h9999_9999; st_req = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("pre-reset mem_wr", {31'd0, mem_wr}, 32'd1);
        #2 rst_in = 1'b0;
        #1;
        chk("async reset mem_a", mem_a, 32'd0);
        chk("async reset mem_wr/dout", {23'd0, mem_wr, mem_dout}, 32'd0);
        chk("async reset st_done", {31'd0, st_done}, 32'd0);
        st_req = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        do_txn("post-reset ld", 0, 32'h300, 2'd0, 32'h0, 0, 0, 0, dk, d, nw);
        chk("post-reset done cycle", dk, 3);
        chk("post-reset data", d, 32'h0000_005A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
